rgb_sequencer: RTL and testbench

- Controller that runs an RGB LED colour sequence.
- Owns the tick prescaler: drives its limit and reset, and consumes its single-cycle clock_enable pulse as tick.
- Steps through a programmable table of NUM_STEPS colour/duration entries, holding each colour for a set number of ticks.
- Drives three PWM channels from the active entry; sits between the register/config interface and the LED pins.

---
 rtl/rgb_sequencer.sv | 170 +++++++++++++++++
 tb/tb_rgb_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sequencer.sv
// RGB LED sequencer: steps through a colour/duration table, paced by prescaler ticks, driving three PWM channels.
// Optional pause input and PAUSED state are built when RGB_SEQ_PAUSE_EN is defined.
module rgb_sequencer #(
  parameter int NUM_STEPS       = 4,
  parameter int COLOR_W         = 8,
  parameter int DUR_W           = 8,
  parameter int PRESCALER_WIDTH = 8,
  parameter int DEFAULT_LIMIT   = 100
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
`ifdef RGB_SEQ_PAUSE_EN
  input  logic                         pause,
`endif
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic [3*COLOR_W-1:0]         cfg_color,
  input  logic [DUR_W-1:0]             cfg_duration,
  input  logic                         limit_we,
  input  logic [PRESCALER_WIDTH-1:0]   limit_wdata,
  input  logic                         tick,
  output logic [PRESCALER_WIDTH-1:0]   presc_limit,
  output logic                         presc_reset,
  output logic                         pwm_r,
  output logic                         pwm_g,
  output logic                         pwm_b,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_STEPS);

`ifdef RGB_SEQ_PAUSE_EN
  typedef enum logic [1:0] {IDLE, ARM, RUN, PAUSED} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
`endif

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           step_idx_reg, step_idx_next;
  logic [DUR_W-1:0]           dur_cnt_reg, dur_cnt_next;
  logic [COLOR_W-1:0]         pwm_cnt_reg, pwm_cnt_next;
  logic                       done_next;
  logic [PRESCALER_WIDTH-1:0] limit_reg;
  logic                       busy_reg, done_reg, presc_reset_reg;
  logic [2:0]                 pwm_reg, duty_hit;

  logic [3*COLOR_W-1:0] color_mem [NUM_STEPS];
  logic [DUR_W-1:0]     dur_mem   [NUM_STEPS];

  logic [DUR_W-1:0]     cur_dur, last_cnt;
  logic [3*COLOR_W-1:0] nxt_color;
  logic                 is_last;

  // Table is cleared by reset, so it is kept in flops rather than block RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        color_mem[i] <= '0;
        dur_mem[i]   <= '0;
      end
    end else if (cfg_we) begin
      color_mem[cfg_addr] <= cfg_color;
      dur_mem[cfg_addr]   <= cfg_duration;
    end
  end

  assign cur_dur  = dur_mem[step_idx_reg];
  assign last_cnt = (cur_dur == '0) ? '0 : cur_dur - DUR_W'(1);
  assign is_last  = (step_idx_reg == IDX_W'(NUM_STEPS - 1));

  always_comb begin
    state_next    = state_reg;
    step_idx_next = step_idx_reg;
    dur_cnt_next  = dur_cnt_reg;
    pwm_cnt_next  = pwm_cnt_reg;
    done_next     = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (start) state_next = ARM;
        ARM: begin
          step_idx_next = '0;
          dur_cnt_next  = '0;
          pwm_cnt_next  = '0;
          state_next    = RUN;
        end
        RUN: begin
          pwm_cnt_next = pwm_cnt_reg + COLOR_W'(1);
`ifdef RGB_SEQ_PAUSE_EN
          if (pause) begin
            state_next = PAUSED;
          end else
`endif
          if (tick) begin
            if (dur_cnt_reg == last_cnt) begin
              dur_cnt_next = '0;
              if (!is_last) begin
                step_idx_next = step_idx_reg + IDX_W'(1);
              end else if (loop_en) begin
                step_idx_next = '0;
              end else begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
            end else begin
              dur_cnt_next = dur_cnt_reg + DUR_W'(1);
            end
          end
        end
`ifdef RGB_SEQ_PAUSE_EN
        PAUSED: begin
          if (!pause) begin
            state_next   = RUN;
            pwm_cnt_next = '0;
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // PWM outputs are registered from next-cycle counter/step so they line up with step_idx.
  assign nxt_color = color_mem[step_idx_next];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_duty
      assign duty_hit[gi] = (pwm_cnt_next < nxt_color[gi*COLOR_W +: COLOR_W]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      step_idx_reg    <= '0;
      dur_cnt_reg     <= '0;
      pwm_cnt_reg     <= '0;
      limit_reg       <= PRESCALER_WIDTH'(DEFAULT_LIMIT);
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      presc_reset_reg <= 1'b1;
      pwm_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      step_idx_reg    <= step_idx_next;
      dur_cnt_reg     <= dur_cnt_next;
      pwm_cnt_reg     <= pwm_cnt_next;
      if (limit_we && state_reg == IDLE) limit_reg <= limit_wdata;
      busy_reg        <= (state_next != IDLE);
      done_reg        <= done_next;
      presc_reset_reg <= (state_next != RUN);
      pwm_reg         <= (state_next == RUN) ? duty_hit : 3'b000;
    end
  end

  assign presc_limit = limit_reg;
  assign presc_reset = presc_reset_reg;
  assign pwm_r       = pwm_reg[2];
  assign pwm_g       = pwm_reg[1];
  assign pwm_b       = pwm_reg[0];
  assign step_idx    = step_idx_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed testbench for rgb_sequencer; inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_rgb_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, stop, loop_en, cfg_we, limit_we, tick;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_color;
  logic [7:0]  cfg_duration, limit_wdata, presc_limit;
  logic        presc_reset, pwm_r, pwm_g, pwm_b, busy, done;
  logic [1:0]  step_idx;
`ifdef RGB_SEQ_PAUSE_EN
  logic        pause = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rgb_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
`ifdef RGB_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_color(cfg_color), .cfg_duration(cfg_duration),
    .limit_we(limit_we), .limit_wdata(limit_wdata), .tick(tick),
    .presc_limit(presc_limit), .presc_reset(presc_reset),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [23:0] c, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_color = c; cfg_duration = d;
    step_clk();
    cfg_we = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1; step_clk(); start = 1'b0; step_clk();
  endtask

  task automatic idle_then_tick();
    repeat (9) step_clk();
    tick = 1'b1; step_clk(); tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (2) step_clk(); reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || presc_reset !== 1'b1 || step_idx !== 2'd0 ||
        presc_limit !== 8'd100 || {pwm_r, pwm_g, pwm_b} !== 3'b000)
      begin bad++; $display("FAIL reset: busy=%b done=%b presc_reset=%b step=%0d limit=%0d pwm=%b%b%b, need 0 0 1 0 100 000",
        busy, done, presc_reset, step_idx, presc_limit, pwm_r, pwm_g, pwm_b); end
    $display("reset: busy=%b presc_reset=%b limit=%0d", busy, presc_reset, presc_limit);
  endtask

  task automatic test_limit_idle();
    limit_we = 1'b1; limit_wdata = 8'd25; step_clk(); limit_we = 1'b0;
    total++;
    if (presc_limit !== 8'd25) begin bad++; $display("FAIL limit_idle: got %0d need 25", presc_limit); end
    $display("limit write in IDLE: presc_limit=%0d", presc_limit);
  endtask

  task automatic load_table();
    write_entry(2'd0, 24'hFF0000, 8'd2);
    write_entry(2'd1, 24'h00FF00, 8'd3);
    write_entry(2'd2, 24'h0000FF, 8'd1);
    write_entry(2'd3, 24'h808080, 8'd0);
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_step [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    int lows = 0, gb_hi = 0, dones = 0;
    loop_en = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    total++;
    if (busy !== 1'b1 || presc_reset !== 1'b1)
      begin bad++; $display("FAIL arm: busy=%b presc_reset=%b need 1 1", busy, presc_reset); end
    step_clk();
    total++;
    if (presc_reset !== 1'b0 || step_idx !== 2'd0)
      begin bad++; $display("FAIL run_entry: presc_reset=%b step=%0d need 0 0", presc_reset, step_idx); end
    for (int t = 1; t <= 7; t++) begin
      for (int i = 0; i < 9; i++) begin
        if (t == 3 && i == 0) begin limit_we = 1'b1; limit_wdata = 8'd7; end
        if (step_idx == 2'd0) begin
          if (!pwm_r) lows++;
          if (pwm_g || pwm_b) gb_hi++;
        end
        if (done) dones++;
        step_clk();
        limit_we = 1'b0;
      end
      if (done) dones++;
      tick = 1'b1; step_clk(); tick = 1'b0;
      total++;
      if (step_idx !== exp_step[t-1])
        begin bad++; $display("FAIL oneshot_step: after tick %0d step=%0d need %0d", t, step_idx, exp_step[t-1]); end
      $display("oneshot tick %0d: step=%0d busy=%b done=%b", t, step_idx, busy, done);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1)
      begin bad++; $display("FAIL oneshot_end: busy=%b done=%b need 0 1", busy, done); end
    total++;
    if (dones != 0) begin bad++; $display("FAIL early_done: %0d pulses need 0", dones); end
    total++;
    if (lows != 0 || gb_hi != 0)
      begin bad++; $display("FAIL step0_pwm: red lows=%0d g/b highs=%0d need 0 0", lows, gb_hi); end
    total++;
    if (presc_limit !== 8'd25) begin bad++; $display("FAIL limit_run: got %0d need 25", presc_limit); end
    step_clk();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width: done=%b need 0", done); end
  endtask

  task automatic test_loop();
    int dones = 0;
    loop_en = 1'b1;
    begin_run();
    for (int t = 1; t <= 7; t++) begin
      repeat (9) begin if (done) dones++; step_clk(); end
      tick = 1'b1; step_clk(); tick = 1'b0;
      if (done) dones++;
    end
    step_clk(); if (done) dones++;
    total++;
    if (step_idx !== 2'd0 || busy !== 1'b1 || dones != 0)
      begin bad++; $display("FAIL loop_wrap: step=%0d busy=%b dones=%0d need 0 1 0", step_idx, busy, dones); end
    $display("loop after tick 7: step=%0d busy=%b", step_idx, busy);
    stop = 1'b1; step_clk(); stop = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic test_stop_mid();
    begin_run();
    repeat (5) idle_then_tick();
    total++;
    if (step_idx !== 2'd2 || {pwm_r, pwm_g, pwm_b} !== 3'b001)
      begin bad++; $display("FAIL step2_pwm: step=%0d pwm=%b%b%b need 2 001", step_idx, pwm_r, pwm_g, pwm_b); end
    stop = 1'b1; step_clk(); stop = 1'b0;
    total++;
    if (busy !== 1'b0 || presc_reset !== 1'b1 || {pwm_r, pwm_g, pwm_b} !== 3'b000 ||
        step_idx !== 2'd2 || done !== 1'b0)
      begin bad++; $display("FAIL stop_mid: busy=%b presc_reset=%b pwm=%b%b%b step=%0d done=%b need 0 1 000 2 0",
        busy, presc_reset, pwm_r, pwm_g, pwm_b, step_idx, done); end
    step_clk();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_done: done=%b busy=%b need 0 0", done, busy); end
    $display("stop in step 2: busy=%b step=%0d", busy, step_idx);
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; step_clk(); start = 1'b0; stop = 1'b0;
    step_clk();
    total++;
    if (busy !== 1'b0 || presc_reset !== 1'b1)
      begin bad++; $display("FAIL start_stop: busy=%b presc_reset=%b need 0 1", busy, presc_reset); end
    $display("start+stop together: busy=%b", busy);
  endtask

`ifdef RGB_SEQ_PAUSE_EN
  task automatic test_pause();
    int moved = 0;
    begin_run();
    repeat (4) idle_then_tick();
    pause = 1'b1; step_clk();
    total++;
    if (step_idx !== 2'd1 || busy !== 1'b1 || presc_reset !== 1'b1 || {pwm_r, pwm_g, pwm_b} !== 3'b000)
      begin bad++; $display("FAIL paused: step=%0d busy=%b presc_reset=%b pwm=%b%b%b need 1 1 1 000",
        step_idx, busy, presc_reset, pwm_r, pwm_g, pwm_b); end
    for (int i = 0; i < 49; i++) begin
      tick = (i % 10 == 5); step_clk(); tick = 1'b0;
      if (step_idx !== 2'd1 || pwm_g !== 1'b0) moved++;
    end
    total++;
    if (moved != 0) begin bad++; $display("FAIL pause_hold: %0d bad cycles need 0", moved); end
    pause = 1'b0; step_clk();
    total++;
    if (presc_reset !== 1'b0 || step_idx !== 2'd1 || busy !== 1'b1)
      begin bad++; $display("FAIL resume: presc_reset=%b step=%0d busy=%b need 0 1 1", presc_reset, step_idx, busy); end
    idle_then_tick();
    total++;
    if (step_idx !== 2'd2) begin bad++; $display("FAIL pause_resume_tick: step=%0d need 2", step_idx); end
    $display("pause in step 1: step after one more tick=%0d", step_idx);
    stop = 1'b1; step_clk(); stop = 1'b0;
  endtask
`endif

  task automatic test_duty();
    int hi = 0, gb = 0;
    write_entry(2'd0, 24'h400000, 8'd255);
    begin_run();
    for (int i = 0; i < 512; i++) begin
      if (pwm_r) hi++;
      if (pwm_g || pwm_b) gb++;
      step_clk();
    end
    total++;
    if (hi != 128 || gb != 0) begin bad++; $display("FAIL duty_40: red high=%0d g/b high=%0d need 128 0", hi, gb); end
    $display("duty 0x40: red high %0d of 512", hi);
    stop = 1'b1; step_clk(); stop = 1'b0;
    write_entry(2'd0, 24'hFF0000, 8'd255);
    begin_run();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_r) hi++;
      step_clk();
    end
    total++;
    if (hi != 255) begin bad++; $display("FAIL duty_ff: red high=%0d need 255", hi); end
    $display("duty 0xFF: red high %0d of 256", hi);
  endtask

  task automatic test_reset_mid();
    int hi = 0;
    reset = 1'b1; step_clk(); reset = 1'b0;
    total++;
    if (busy !== 1'b0 || presc_reset !== 1'b1 || presc_limit !== 8'd100 || pwm_r !== 1'b0)
      begin bad++; $display("FAIL reset_mid: busy=%b presc_reset=%b limit=%0d pwm_r=%b need 0 1 100 0",
        busy, presc_reset, presc_limit, pwm_r); end
    begin_run();
    for (int i = 0; i < 20; i++) begin
      if (pwm_r) hi++;
      step_clk();
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL table_cleared: red high=%0d need 0", hi); end
    $display("reset mid-run: limit=%0d red high after restart=%0d", presc_limit, hi);
    stop = 1'b1; step_clk(); stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_color = '0; cfg_duration = '0; limit_we = 1'b0; limit_wdata = '0; tick = 1'b0;
    test_reset();
    test_limit_idle();
    load_table();
    test_oneshot();
    test_loop();
    test_stop_mid();
    test_start_stop();
`ifdef RGB_SEQ_PAUSE_EN
    test_pause();
`endif
    test_duty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
